// File: rtl/hazard_detection_unit_pkg.sv
// Shared definitions for the ID-stage hazard detection unit: FSM state
// encodings, the hard-wired zero register address and the HALT drain length.
package hazard_detection_unit_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // HALT needs three further cycles after leaving ID to retire through WB.
   localparam int DRAIN_LEN   = 3;
   localparam int DRAIN_CNT_W = 2;
   localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_LEN - 1);

endpackage

// File: rtl/hazard_comparator.sv
// Purely combinational register-dependence comparator. Flags the three hazards
// that forwarding cannot cover: load-use, and a branch resolved in ID that
// depends on an ALU result still in EX or on a load still in MEM.
module hazard_comparator
   import hazard_detection_unit_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic [ADDR_W-1:0] i_rs_if_id,
   input  logic [ADDR_W-1:0] i_rt_if_id,
   input  logic              i_uses_rt_id,
   input  logic              i_is_branch_id,
   input  logic [ADDR_W-1:0] i_rd_id_ex,
   input  logic              i_reg_write_id_ex,
   input  logic              i_mem_read_id_ex,
   input  logic [ADDR_W-1:0] i_rd_ex_mem,
   input  logic              i_mem_read_ex_mem,
   output logic              o_load_use,
   output logic              o_br_alu,
   output logic              o_br_mem
);

   // r0 never carries a real dependence; rt only matters when ID reads it.
   function automatic logic reg_match(input logic [ADDR_W-1:0] rd,
                                      input logic [ADDR_W-1:0] rs,
                                      input logic [ADDR_W-1:0] rt,
                                      input logic              uses_rt);
      return (rd != ADDR_W'(REG_ZERO)) && ((rd == rs) || (uses_rt && (rd == rt)));
   endfunction

   // Hazard flags from current pipeline-register contents.
   always_comb begin
      o_load_use = i_mem_read_id_ex &&
                   reg_match(i_rd_id_ex, i_rs_if_id, i_rt_if_id, i_uses_rt_id);
      o_br_alu   = i_is_branch_id && i_reg_write_id_ex &&
                   reg_match(i_rd_id_ex, i_rs_if_id, i_rt_if_id, i_uses_rt_id);
      o_br_mem   = i_is_branch_id && i_mem_read_ex_mem &&
                   reg_match(i_rd_ex_mem, i_rs_if_id, i_rt_if_id, i_uses_rt_id);
   end

endmodule

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard detection and pipeline control: stalls on unresolvable
// dependences, flushes IF/ID on taken branches, sequences the HALT drain
// (RUN -> DRAIN -> HALTED) and keeps stall/flush statistics.
// Define HAZARD_STATS_EN to build the statistics counters; otherwise the
// counter outputs are tied to zero.
module hazard_detection_unit
   import hazard_detection_unit_pkg::*;
#(
   parameter int CANT_BITS_ADDR_REGISTROS = 5,
   parameter int CANT_BITS_CONTADOR       = 32
) (
   input  logic                                i_clock,
   input  logic                                i_soft_reset,
   input  logic                                i_enable,
   input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_rs_if_id,
   input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_rt_if_id,
   input  logic                                i_uses_rt_id,
   input  logic                                i_is_branch_id,
   input  logic                                i_halt_id,
   input  logic                                i_branch_taken,
   input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_rd_id_ex,
   input  logic                                i_reg_write_id_ex,
   input  logic                                i_mem_read_id_ex,
   input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_rd_ex_mem,
   input  logic                                i_mem_read_ex_mem,
   output logic                                o_pc_write,
   output logic                                o_if_id_write,
   output logic                                o_id_ex_bubble,
   output logic                                o_if_id_flush,
   output logic                                o_halted,
   output logic [CANT_BITS_CONTADOR-1:0]       o_contador_stalls,
   output logic [CANT_BITS_CONTADOR-1:0]       o_contador_flushes
);

   state_e                 state_q, state_d;
   logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
   logic                   load_use, br_alu, br_mem, stall;

   hazard_comparator #(
      .ADDR_W (CANT_BITS_ADDR_REGISTROS)
   ) u_hazard_comparator (
      .i_rs_if_id        (i_rs_if_id),
      .i_rt_if_id        (i_rt_if_id),
      .i_uses_rt_id      (i_uses_rt_id),
      .i_is_branch_id    (i_is_branch_id),
      .i_rd_id_ex        (i_rd_id_ex),
      .i_reg_write_id_ex (i_reg_write_id_ex),
      .i_mem_read_id_ex  (i_mem_read_id_ex),
      .i_rd_ex_mem       (i_rd_ex_mem),
      .i_mem_read_ex_mem (i_mem_read_ex_mem),
      .o_load_use        (load_use),
      .o_br_alu          (br_alu),
      .o_br_mem          (br_mem)
   );

   assign stall = load_use || br_alu || br_mem;

   // State and drain counter registers.
   always_ff @(posedge i_clock or posedge i_soft_reset) begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge value of every other flop, independent of statement order.
      if (i_soft_reset) begin
         state_q     <= ST_RUN;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   // Next-state logic; nothing advances while the debug unit holds the pipe.
   always_comb begin
      // NOTE: hold-by-default assignments keep this block free of latches
      // on paths that do not change state.
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      if (i_enable) begin
         case (state_q)
            ST_RUN: begin
               if (!stall && i_halt_id) begin
                  state_d     = ST_DRAIN;
                  drain_cnt_d = '0;
               end
            end
            ST_DRAIN: begin
               if (drain_cnt_q == DRAIN_LAST) begin
                  state_d = ST_HALTED;
               end else begin
                  drain_cnt_d = drain_cnt_q + DRAIN_CNT_W'(1);
               end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
         endcase
      end
   end

   // Output decode: reset, then debug hold, then per-state pipeline control.
   always_comb begin
      o_pc_write     = 1'b0;
      o_if_id_write  = 1'b0;
      o_id_ex_bubble = 1'b1;
      o_if_id_flush  = 1'b0;
      o_halted       = (state_q == ST_HALTED);
      if (i_soft_reset) begin
         o_halted = 1'b0;
      end else if (!i_enable) begin
         o_id_ex_bubble = 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (stall) begin
                  o_id_ex_bubble = 1'b1;
               end else if (i_halt_id) begin
                  // HALT itself moves into EX; fetch stops behind it.
                  o_id_ex_bubble = 1'b0;
               end else begin
                  o_pc_write     = 1'b1;
                  o_if_id_write  = 1'b1;
                  o_id_ex_bubble = 1'b0;
                  o_if_id_flush  = i_branch_taken;
               end
            end
            default: o_id_ex_bubble = 1'b1;
         endcase
      end
   end

`ifdef HAZARD_STATS_EN
   logic [CANT_BITS_CONTADOR-1:0] stall_cnt_q, stall_cnt_d;
   logic [CANT_BITS_CONTADOR-1:0] flush_cnt_q, flush_cnt_d;
   logic                          stall_evt, flush_evt;

   // A stall is only counted when it actually freezes the front end.
   assign stall_evt = i_enable && (state_q == ST_RUN) && stall;
   assign flush_evt = i_enable && o_if_id_flush;

   // Saturating statistics increments.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_evt && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CANT_BITS_CONTADOR'(1);
      end
      if (flush_evt && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CANT_BITS_CONTADOR'(1);
      end
   end

   // Statistics registers.
   always_ff @(posedge i_clock or posedge i_soft_reset) begin
      if (i_soft_reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign o_contador_stalls  = stall_cnt_q;
   assign o_contador_flushes = flush_cnt_q;
`else
   assign o_contador_stalls  = '0;
   assign o_contador_flushes = '0;
`endif

endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

ID-stage hazard and pipeline-control block of the MIPS core, directly upstream of `forwarding_unit`. It detects the hazards forwarding cannot resolve: load-use, and branch-in-ID operand dependences. It drives PC / IF-ID write enables, the ID/EX bubble and the IF/ID flush. It also sequences the HALT drain and keeps stall/flush statistics for the debug unit.

## Interface
- `CANT_BITS_ADDR_REGISTROS`, 5, register address width
- `CANT_BITS_CONTADOR`, 32, statistics counter width
- `i_clock` in 1: rising-edge clock
- `i_soft_reset` in 1: asynchronous, active-high reset
- `i_enable` in 1: pipeline advance enable from debug unit (step/continuous mode)
- `i_rs_if_id`, `i_rt_if_id` in 5: source registers of the instruction in ID
- `i_uses_rt_id` in 1: instruction in ID reads rt
- `i_is_branch_id` in 1: instruction in ID is BEQ/BNE/JR/JALR (resolved in ID)
- `i_halt_id` in 1: instruction in ID is HALT
- `i_branch_taken` in 1: branch/jump in ID redirects PC
- `i_rd_id_ex` in 5: destination of the instruction in EX
- `i_reg_write_id_ex`, `i_mem_read_id_ex` in 1: its control bits
- `i_rd_ex_mem` in 5: destination of the instruction in MEM
- `i_mem_read_ex_mem` in 1: its control bit
- `o_pc_write`, `o_if_id_write` out 1: write enables
- `o_id_ex_bubble` out 1: zero ID/EX control signals
- `o_if_id_flush` out 1: replace IF/ID with NOP
- `o_halted` out 1: pipeline fully drained after HALT
- `o_contador_stalls`, `o_contador_flushes` out `CANT_BITS_CONTADOR`: statistics

## Operation
- Register match `m(rd)`: rd != 0 and (rd == rs, or (`i_uses_rt_id` and rd == rt)).
- `load_use` = `i_mem_read_id_ex` and m(`i_rd_id_ex`).
- `br_alu` = `i_is_branch_id` and `i_reg_write_id_ex` and m(`i_rd_id_ex`).
- `br_mem` = `i_is_branch_id` and `i_mem_read_ex_mem` and m(`i_rd_ex_mem`).
- `stall` = any of the three. A load followed by a dependent branch therefore stalls 2 cycles: `br_alu` then `br_mem`.
- FSM states: RUN, DRAIN, HALTED.
- RUN with stall: `o_pc_write`=0, `o_if_id_write`=0, `o_id_ex_bubble`=1, `o_if_id_flush`=0.
  - Stall has priority; `i_branch_taken` and `i_halt_id` are ignored during a stall.
- RUN without stall:
  - If `i_halt_id`: pc/if_id write 0, bubble 0 (HALT advances to EX), flush 0; next state DRAIN with drain counter=0.
  - Else: pc/if_id write 1, bubble 0, `o_if_id_flush`=`i_branch_taken`.
- DRAIN: pc/if_id write 0, bubble 1. Drain counter increments each enabled cycle. At counter==2 (3 cycles, HALT reaches WB) → HALTED.
- HALTED: pc/if_id write 0, bubble 1, `o_halted`=1. Only reset leaves HALTED.
- `i_enable`=0 overrides all states: pc/if_id write 0, bubble 0, flush 0. FSM, drain counter and statistics hold.
- Statistics (enabled cycles only):
  - stall counter +1 per stall cycle.
  - flush counter +1 per cycle with `o_if_id_flush`=1.
  - Both saturate at all-ones.

## Timing
- Hazard outputs are combinational from current inputs and state, so the stall takes effect in the same cycle.
- State, drain counter and statistics are registered on the rising edge of `i_clock`.
- Reset, asynchronous and held: state RUN, counters 0, `o_pc_write`=0, `o_if_id_write`=0, `o_id_ex_bubble`=1, `o_if_id_flush`=0, `o_halted`=0.
- First enabled edge after reset deassertion operates normally.
- Reset asserted mid-DRAIN or in HALTED returns to RUN immediately and clears counters.
- HALT to `o_halted`: 1 cycle in RUN + 3 cycles in DRAIN; `o_halted` is high from the 5th enabled edge-relative cycle onward.

## Configuration
- `HAZARD_STATS_EN` defined: both counters implemented as above.
- Not defined: no counter registers; `o_contador_stalls` and `o_contador_flushes` are tied to 0. Hazard and FSM behaviour is unchanged.

## Structure
- Shared package/header holds: FSM state encodings (RUN=0, DRAIN=1, HALTED=2), `REG_ZERO`=5'd0, drain length constant 3.
- One sub-module, `hazard_comparator`: purely combinational; computes `load_use`, `br_alu`, `br_mem` from addresses and control bits.
- Top level holds the FSM, output decode and counters.

## Test plan
- Load-use: EX `lw` rd=5, ID rs=5, enable=1 → one cycle with pc_write=0, if_id_write=0, bubble=1; stall counter=1. Then EX mem_read=0, so no stall.
- Dependent branch: EX `lw` rd=3, ID `beq` rs=3 → two stall cycles (`br_alu`, then `br_mem`). Then branch_taken=1 → flush=1; stall counter=2, flush counter=1.
- r0 and rt gating: EX `lw` rd=0, ID rs=0 → no stall. rd=7, rt=7, uses_rt=0 → no stall.
- Stall priority: load-use hazard with i_branch_taken=1 and i_halt_id=1 in the same cycle → stall only, flush=0, state stays RUN.
- HALT drain with i_enable toggled low for 2 cycles mid-DRAIN → drain pauses, outputs frozen (writes 0, bubble 0). `o_halted` rises after 3 enabled DRAIN cycles.
- Reset asserted asynchronously while HALTED → `o_halted`=0, state RUN, counters 0 before the next clock edge.
